pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the single-cycle MIPS core. It is the successor to the fixed-width PC register.
- Selects the next fetch address from four sources: sequential, PC-relative conditional branch, absolute jump, and jump-register.
- Adds fetch stall, an exception vector with EPC capture, ERET, misaligned-target trapping, and a circular link stack that supplies return addresses.

Parameters:
- WIDTH, 32: PC / address width; must be at least 28.
- RESET_VECTOR, 32'h0000_3000: PC value after reset.
- EXC_VECTOR, 32'h0000_4180: PC value on exception entry.
- RAS_DEPTH, 4: number of link-stack entries; power of two, at least 2.

Ports:
- Clk  in  1  rising-edge clock.
- PcReSet_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and link stack this cycle.
- Branch  in  2  next-PC mode: 00 sequential, 01 conditional branch, 10 jump register, 11 jump.
- Taken  in  1  branch condition result; used only in mode 01.
- Address  in  WIDTH  sign-extended word offset for mode 01.
- JumpTarget  in  26  instr_index for mode 11.
- RegTarget  in  WIDTH  register value for mode 10.
- Link  in  1  with mode 10 or 11, push PC+4 onto the link stack.
- Ret  in  1  with mode 10, pop the link stack and use its top as the target.
- Exception  in  1  external exception request.
- Eret  in  1  return from exception.
- PC  out  WIDTH  current fetch address.
- EPC  out  WIDTH  saved exception PC.
- AddrErr  out  1  registered: last update trapped on a misaligned target.
- RasEmpty  out  1  link stack holds no entries.
- RasFull  out  1  link stack holds RAS_DEPTH entries.

Behaviour:
- Reset (PcReSet_n low, asynchronous; takes effect immediately, including mid-operation):
  - PC = RESET_VECTOR, EPC = 0, AddrErr = 0.
  - Link-stack pointer and count = 0, so RasEmpty = 1 and RasFull = 0.
  - Stack contents are don't-care.
- All other updates happen on the rising edge of Clk. Latency: next-PC is combinational from the inputs and is registered in one cycle.
- Per-edge priority, highest first:
  1. Exception: PC = EXC_VECTOR; EPC = PC; AddrErr = 0; link stack unchanged; Stall ignored.
  2. Eret: PC = EPC; Stall ignored.
  3. Stall: PC, EPC, AddrErr and the link stack all hold. Link and Ret are ignored.
  4. Mode update (below).
- Mode 00, and mode 01 with Taken = 0: PC = PC + 4.
- Mode 01 with Taken = 1: PC = PC + 4 + (Address << 2), arithmetic modulo 2^WIDTH.
- Mode 11: PC = {(PC+4)[WIDTH-1:28], JumpTarget, 2'b00}. The upper bits come from PC+4, so a jump in the last slot of a 256 MB region uses the next region.
- Mode 10, target selection:
  - Target = top of link stack if Ret = 1 and RasEmpty = 0.
  - Otherwise target = RegTarget (Ret on an empty stack falls back silently).
- Misaligned target (mode 10 only): if target[1:0] != 0, the update traps instead of jumping.
  - PC = EXC_VECTOR, EPC = PC, AddrErr = 1.
  - No push and no pop.
- Otherwise AddrErr = 0 on every non-stalled update.
- Link-stack push (Link = 1 in mode 10 or 11, not trapping): write PC+4 at the pointer, pointer + 1 mod RAS_DEPTH, count saturates at RAS_DEPTH.
  - A push while full overwrites the oldest entry; RasFull stays 1.
- Link-stack pop (Ret = 1 in mode 10, stack not empty): pointer - 1, count - 1.
- Pop and push together (Ret = 1 and Link = 1, stack not empty):
  - Target is the old top.
  - The new PC+4 replaces that entry; pointer and count are unchanged.
- Link or Ret asserted in mode 00 or 01 is ignored.

Test Plan:
- Reset release, four unstalled mode-00 cycles -> PC 0x3000, 0x3004, 0x3008, 0x300C, 0x3010.
- PC = 0x3010, mode 01, Address = 0xFFFF_FFFC:
  - Taken = 1 -> PC = 0x3004.
  - Taken = 0 -> PC = 0x3014.
  - Stall held 2 cycles during the same request -> PC stays 0x3010 for 2 cycles, then updates.
- PC = 0x0FFF_FFFC, mode 11, JumpTarget = 0x0000010 -> PC = 0x1000_0040.
- Link stack:
  - Five calls (mode 11, Link = 1) from PCs A..E with RAS_DEPTH = 4 -> RasFull = 1.
  - Five returns (mode 10, Ret = 1, RegTarget = 0x5000) -> targets E+4, D+4, C+4, B+4, then 0x5000 with RasEmpty = 1.
- Mode 10 with RegTarget = 0x3002 at PC = 0x3020 -> PC = 0x4180, EPC = 0x3020, AddrErr = 1; then Eret -> PC = 0x3020, AddrErr = 0.
- Priority and reset:
  - Exception and Stall together at PC = 0x3100 -> PC = 0x4180, EPC = 0x3100.
  - PcReSet_n pulsed low between clock edges -> PC = 0x3000 immediately, RasEmpty = 1.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the single-cycle MIPS core: sequential,
// branch, jump and jump-register next-PC selection with fetch stall,
// exception entry/return, misaligned-target trapping and a circular
// return-address (link) stack.
module pc_gen #(
   parameter int unsigned           WIDTH        = 32,
   parameter logic [WIDTH-1:0]      RESET_VECTOR = 'h0000_3000,
   parameter logic [WIDTH-1:0]      EXC_VECTOR   = 'h0000_4180,
   parameter int unsigned           RAS_DEPTH    = 4
) (
   input  logic             Clk,
   input  logic             PcReSet_n,
   input  logic             Stall,
   input  logic [1:0]       Branch,
   input  logic             Taken,
   input  logic [WIDTH-1:0] Address,
   input  logic [25:0]      JumpTarget,
   input  logic [WIDTH-1:0] RegTarget,
   input  logic             Link,
   input  logic             Ret,
   input  logic             Exception,
   input  logic             Eret,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] EPC,
   output logic             AddrErr,
   output logic             RasEmpty,
   output logic             RasFull
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      MODE_SEQ  = 2'b00,
      MODE_BR   = 2'b01,
      MODE_JR   = 2'b10,
      MODE_JMP  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             addr_err_q, addr_err_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [WIDTH-1:0] ras_d [RAS_DEPTH];

   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] jmp_target;
   logic [WIDTH-1:0] jr_target;
   logic [PTR_W-1:0] top_idx;
   logic             ras_empty;
   logic             ras_full;
   logic             pop_ok;
   mode_e            mode;

   // Candidate targets; the jump keeps the 256 MB region bits of PC+4.
   always_comb begin
      mode       = mode_e'(Branch);
      pc_plus4   = pc_q + WIDTH'(4);
      br_target  = pc_plus4 + (Address << 2);
      jmp_target = (pc_plus4 & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({JumpTarget, 2'b00});
      ras_empty  = (cnt_q == '0);
      ras_full   = (cnt_q == CNT_W'(RAS_DEPTH));
      top_idx    = ptr_q - PTR_W'(1);
      pop_ok     = Ret && !ras_empty;
      jr_target  = pop_ok ? ras_q[top_idx] : RegTarget;
   end

   // Next-state selection in priority order: exception, eret, stall, mode.
   always_comb begin
      pc_d       = pc_q;
      epc_d      = epc_q;
      addr_err_d = addr_err_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      ras_d      = ras_q;
      if (Exception) begin
         pc_d       = EXC_VECTOR;
         epc_d      = pc_q;
         addr_err_d = 1'b0;
      end else if (Eret) begin
         pc_d       = epc_q;
         addr_err_d = 1'b0;
      end else if (!Stall) begin
         addr_err_d = 1'b0;
         case (mode)
            MODE_SEQ: pc_d = pc_plus4;
            MODE_BR:  pc_d = Taken ? br_target : pc_plus4;
            MODE_JR: begin
               if (jr_target[1:0] != 2'b00) begin
                  pc_d       = EXC_VECTOR;
                  epc_d      = pc_q;
                  addr_err_d = 1'b1;
               end else begin
                  pc_d = jr_target;
                  // Pop+push replaces the top entry in place.
                  if (pop_ok && Link) begin
                     ras_d[top_idx] = pc_plus4;
                  end else if (pop_ok) begin
                     ptr_d = ptr_q - PTR_W'(1);
                     cnt_d = cnt_q - CNT_W'(1);
                  end else if (Link) begin
                     ras_d[ptr_q] = pc_plus4;
                     ptr_d        = ptr_q + PTR_W'(1);
                     cnt_d        = ras_full ? cnt_q : cnt_q + CNT_W'(1);
                  end
               end
            end
            MODE_JMP: begin
               pc_d = jmp_target;
               if (Link) begin
                  ras_d[ptr_q] = pc_plus4;
                  ptr_d        = ptr_q + PTR_W'(1);
                  cnt_d        = ras_full ? cnt_q : cnt_q + CNT_W'(1);
               end
            end
            default: pc_d = pc_plus4;
         endcase
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge PcReSet_n) begin
      if (!PcReSet_n) begin
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         addr_err_q <= 1'b0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         addr_err_q <= addr_err_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Link-stack storage; contents are meaningless while the count is zero.
   always_ff @(posedge Clk) begin
      ras_q <= ras_d;
   end

   assign PC       = pc_q;
   assign EPC      = epc_q;
   assign AddrErr  = addr_err_q;
   assign RasEmpty = ras_empty;
   assign RasFull  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with default parameters.
module tb_pc_gen;

   logic        Clk;
   logic        PcReSet_n;
   logic        Stall;
   logic [1:0]  Branch;
   logic        Taken;
   logic [31:0] Address;
   logic [25:0] JumpTarget;
   logic [31:0] RegTarget;
   logic        Link;
   logic        Ret;
   logic        Exception;
   logic        Eret;
   logic [31:0] PC;
   logic [31:0] EPC;
   logic        AddrErr;
   logic        RasEmpty;
   logic        RasFull;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   pc_gen #(
      .WIDTH        (32),
      .RESET_VECTOR (32'h0000_3000),
      .EXC_VECTOR   (32'h0000_4180),
      .RAS_DEPTH    (4)
   ) dut (
      .Clk        (Clk),
      .PcReSet_n  (PcReSet_n),
      .Stall      (Stall),
      .Branch     (Branch),
      .Taken      (Taken),
      .Address    (Address),
      .JumpTarget (JumpTarget),
      .RegTarget  (RegTarget),
      .Link       (Link),
      .Ret        (Ret),
      .Exception  (Exception),
      .Eret       (Eret),
      .PC         (PC),
      .EPC        (EPC),
      .AddrErr    (AddrErr),
      .RasEmpty   (RasEmpty),
      .RasFull    (RasFull)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      PcReSet_n = 1'b0; Stall = 1'b0; Branch = 2'b00; Taken = 1'b0;
      Address = '0; JumpTarget = '0; RegTarget = '0; Link = 1'b0;
      Ret = 1'b0; Exception = 1'b0; Eret = 1'b0;
      #12;
      chk("rst_pc", PC, 32'h3000);
      chk("rst_epc", EPC, 32'h0);
      chk("rst_aerr", {31'b0, AddrErr}, 32'd0);
      chk("rst_empty", {31'b0, RasEmpty}, 32'd1);
      chk("rst_full", {31'b0, RasFull}, 32'd0);
      PcReSet_n = 1'b1;

      // Sequential fetch
      step(); chk("seq1", PC, 32'h3004);
      step(); chk("seq2", PC, 32'h3008);
      step(); chk("seq3", PC, 32'h300C);
      step(); chk("seq4", PC, 32'h3010);

      // Backward branch taken
      Branch = 2'b01; Address = 32'hFFFF_FFFC; Taken = 1'b1;
      step(); chk("br_taken", PC, 32'h3004);
      Branch = 2'b00;
      step(); step(); step(); chk("back_3010a", PC, 32'h3010);
      // Not taken
      Branch = 2'b01; Taken = 1'b0;
      step(); chk("br_not_taken", PC, 32'h3014);
      Taken = 1'b1;
      step(); chk("br_taken2", PC, 32'h3008);
      Branch = 2'b00;
      step(); step(); chk("back_3010b", PC, 32'h3010);
      // Stall during branch request
      Branch = 2'b01; Taken = 1'b1; Stall = 1'b1;
      step(); chk("stall1", PC, 32'h3010);
      step(); chk("stall2", PC, 32'h3010);
      Stall = 1'b0;
      step(); chk("stall_rel", PC, 32'h3004);
      chk("stall_epc", EPC, 32'h0);

      // Jump across 256 MB region boundary
      Branch = 2'b10; RegTarget = 32'h0FFF_FFFC; Taken = 1'b0;
      step(); chk("jr_setup", PC, 32'h0FFF_FFFC);
      Branch = 2'b11; JumpTarget = 26'h000_0010;
      step(); chk("jmp_region", PC, 32'h1000_0040);

      // Five calls
      Link = 1'b1;
      JumpTarget = 26'h100; step(); chk("call_a", PC, 32'h1000_0400);
      JumpTarget = 26'h200; step(); chk("call_b", PC, 32'h1000_0800);
      JumpTarget = 26'h300; step(); chk("call_c", PC, 32'h1000_0C00);
      chk("full_3", {31'b0, RasFull}, 32'd0);
      JumpTarget = 26'h400; step(); chk("call_d", PC, 32'h1000_1000);
      chk("full_4", {31'b0, RasFull}, 32'd1);
      JumpTarget = 26'h500; step(); chk("call_e", PC, 32'h1000_1400);
      chk("full_5", {31'b0, RasFull}, 32'd1);
      chk("nonempty_5", {31'b0, RasEmpty}, 32'd0);

      // Five returns
      Link = 1'b0; Branch = 2'b10; Ret = 1'b1; RegTarget = 32'h5000;
      step(); chk("ret1", PC, 32'h1000_1004);
      chk("ret1_full", {31'b0, RasFull}, 32'd0);
      step(); chk("ret2", PC, 32'h1000_0C04);
      step(); chk("ret3", PC, 32'h1000_0804);
      step(); chk("ret4", PC, 32'h1000_0404);
      chk("ret4_empty", {31'b0, RasEmpty}, 32'd1);
      step(); chk("ret5_fallback", PC, 32'h5000);
      chk("ret5_empty", {31'b0, RasEmpty}, 32'd1);

      // Pop and push together
      Ret = 1'b0; Link = 1'b1; Branch = 2'b11; JumpTarget = 26'h600;
      step(); chk("call_f", PC, 32'h1800);
      Ret = 1'b1; Branch = 2'b10; RegTarget = 32'h7000;
      step(); chk("poppush", PC, 32'h5004);
      chk("poppush_ne", {31'b0, RasEmpty}, 32'd0);
      Link = 1'b0;
      step(); chk("pop_repl", PC, 32'h1804);
      chk("pop_repl_e", {31'b0, RasEmpty}, 32'd1);

      // Misaligned jump-register trap and Eret
      Ret = 1'b0; RegTarget = 32'h3020;
      step(); chk("jr_3020", PC, 32'h3020);
      RegTarget = 32'h3002; Link = 1'b1;
      step(); chk("trap_pc", PC, 32'h4180);
      chk("trap_epc", EPC, 32'h3020);
      chk("trap_aerr", {31'b0, AddrErr}, 32'd1);
      chk("trap_nopush", {31'b0, RasEmpty}, 32'd1);
      Link = 1'b0; Branch = 2'b00; Eret = 1'b1;
      step(); chk("eret_pc", PC, 32'h3020);
      chk("eret_aerr", {31'b0, AddrErr}, 32'd0);
      Eret = 1'b0;

      // Exception beats Stall
      Branch = 2'b10; RegTarget = 32'h3100;
      step(); chk("jr_3100", PC, 32'h3100);
      Branch = 2'b00; Exception = 1'b1; Stall = 1'b1;
      step(); chk("exc_pc", PC, 32'h4180);
      chk("exc_epc", EPC, 32'h3100);
      Exception = 1'b0; Stall = 1'b0;

      // Asynchronous reset between edges
      Branch = 2'b11; Link = 1'b1; JumpTarget = 26'h0D00;
      step(); chk("pre_rst_pc", PC, 32'h3400);
      chk("pre_rst_ne", {31'b0, RasEmpty}, 32'd0);
      Branch = 2'b00; Link = 1'b0;
      #2 PcReSet_n = 1'b0;
      #1;
      chk("async_pc", PC, 32'h3000);
      chk("async_empty", {31'b0, RasEmpty}, 32'd1);
      chk("async_epc", EPC, 32'h0);
      #1 PcReSet_n = 1'b1;
      step(); chk("post_rst", PC, 32'h3004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
